// File: rtl/spi_cfg_master.sv
// SPI mode-0 initiator for the spiking_network_top configuration port.
// Turns a valid/ready byte stream into framed transfers: chip select low,
// WIDTH-bit words MSB-first, then chip select high after the word flagged last.
// Every word shifted in on MISO is returned on rx_data with a one-cycle rx_valid.
module spi_cfg_master #(
    parameter int CLK_DIV = 4,
    parameter int WIDTH   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    input  logic             tx_last,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             sclk,
    output logic             mosi,
    output logic             cs_n,
    input  logic             miso
);

    localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [HW-1:0] HC_LAST = HW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BC_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        XFER  = 3'd2,
        WAIT  = 3'd3,
        HOLD  = 3'd4,
        GAP   = 3'd5
    } state_t;

    state_t           state_r, state_s;
    logic [HW-1:0]    hcnt_r, hcnt_s;
    logic [BW-1:0]    bcnt_r, bcnt_s;
    logic [WIDTH-1:0] tx_sr_r, tx_sr_s;
    logic [WIDTH-1:0] rx_sr_r, rx_sr_s;
    logic [WIDTH-1:0] rx_data_s;
    logic             last_r, last_s;
    logic             sclk_s, mosi_s, cs_n_s, rx_valid_s;
    logic             accept_s, hc_end_s;

    // Handshake and status are decoded straight from the registered state.
    assign tx_ready = rst_n & ((state_r == IDLE) | (state_r == WAIT));
    assign busy     = (state_r != IDLE);
    assign accept_s = tx_valid & tx_ready;
    assign hc_end_s = (hcnt_r == HC_LAST);

    // Next-state and next-output decode for the framing FSM and its datapath.
    always_comb begin
        state_s    = state_r;
        hcnt_s     = hcnt_r;
        bcnt_s     = bcnt_r;
        tx_sr_s    = tx_sr_r;
        rx_sr_s    = rx_sr_r;
        rx_data_s  = rx_data;
        last_s     = last_r;
        sclk_s     = sclk;
        mosi_s     = mosi;
        cs_n_s     = cs_n;
        rx_valid_s = 1'b0;
        case (state_r)
            IDLE, WAIT: begin
                sclk_s = 1'b0;
                if (accept_s) begin
                    tx_sr_s = tx_data;
                    mosi_s  = tx_data[WIDTH-1];
                    last_s  = tx_last;
                    hcnt_s  = {HW{1'b0}};
                    bcnt_s  = {BW{1'b0}};
                    cs_n_s  = 1'b0;
                    state_s = SETUP;
                end else begin
                    // WAIT keeps the frame open; IDLE keeps the target deselected.
                    cs_n_s  = (state_r == IDLE) ? 1'b1 : cs_n;
                    state_s = state_r;
                end
            end
            SETUP: begin
                if (hc_end_s) begin
                    hcnt_s  = {HW{1'b0}};
                    sclk_s  = 1'b1;
                    state_s = XFER;
                end else begin
                    hcnt_s  = hcnt_r + HW'(1);
                end
            end
            XFER: begin
                if (!hc_end_s) begin
                    hcnt_s = hcnt_r + HW'(1);
                end else if (sclk) begin
                    // End of a high phase: sample MISO and drop SCLK.
                    hcnt_s  = {HW{1'b0}};
                    sclk_s  = 1'b0;
                    rx_sr_s = {rx_sr_r[WIDTH-2:0], miso};
                    if (bcnt_r != BC_LAST) begin
                        tx_sr_s = {tx_sr_r[WIDTH-2:0], tx_sr_r[WIDTH-1]};
                        mosi_s  = tx_sr_r[WIDTH-2];
                    end else begin
                        mosi_s  = mosi;
                    end
                end else begin
                    // End of a low phase: either start the next bit or close the word.
                    hcnt_s = {HW{1'b0}};
                    if (bcnt_r == BC_LAST) begin
                        rx_data_s  = rx_sr_r;
                        rx_valid_s = 1'b1;
                        state_s    = last_r ? HOLD : WAIT;
                    end else begin
                        sclk_s = 1'b1;
                        bcnt_s = bcnt_r + BW'(1);
                    end
                end
            end
            HOLD: begin
                if (hc_end_s) begin
                    hcnt_s  = {HW{1'b0}};
                    cs_n_s  = 1'b1;
                    state_s = GAP;
                end else begin
                    hcnt_s  = hcnt_r + HW'(1);
                end
            end
            GAP: begin
                if (hc_end_s) begin
                    hcnt_s  = {HW{1'b0}};
                    state_s = IDLE;
                end else begin
                    hcnt_s  = hcnt_r + HW'(1);
                end
            end
            default: begin
                state_s = IDLE;
                cs_n_s  = 1'b1;
                sclk_s  = 1'b0;
                hcnt_s  = {HW{1'b0}};
            end
        endcase
    end

    // State, counters, shift registers and all SPI outputs; reset aborts any transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            hcnt_r   <= {HW{1'b0}};
            bcnt_r   <= {BW{1'b0}};
            tx_sr_r  <= {WIDTH{1'b0}};
            rx_sr_r  <= {WIDTH{1'b0}};
            last_r   <= 1'b0;
            rx_data  <= {WIDTH{1'b0}};
            rx_valid <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            cs_n     <= 1'b1;
        end else begin
            state_r  <= state_s;
            hcnt_r   <= hcnt_s;
            bcnt_r   <= bcnt_s;
            tx_sr_r  <= tx_sr_s;
            rx_sr_r  <= rx_sr_s;
            last_r   <= last_s;
            rx_data  <= rx_data_s;
            rx_valid <= rx_valid_s;
            sclk     <= sclk_s;
            mosi     <= mosi_s;
            cs_n     <= cs_n_s;
        end
    end

endmodule

// File: tb/tb_spi_cfg_master.sv
// Bench for spi_cfg_master (CLK_DIV=4, WIDTH=8). Stimulus pushes the expected
// received word into a queue; a monitor pops and compares on every rx_valid.
// A small target model drives MISO from a pattern word (updated on SCLK fall)
// or loops MOSI back.
module tb_spi_cfg_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       sclk;
    logic       mosi;
    logic       cs_n;
    logic       miso;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;
    int rx_seen = 0;

    logic [7:0] exp_q[$];
    logic       loopback;
    logic [7:0] tgt_word;
    logic [2:0] tgt_cnt;
    logic [7:0] mosi_cap;

    logic watch = 1'b0;
    int   cs_high_cnt = 0;
    int   wait_cyc_cnt = 0;
    int   rxv_cnt = 0;

    spi_cfg_master #(.CLK_DIV(4), .WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_last  (tx_last),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy),
        .sclk     (sclk),
        .mosi     (mosi),
        .cs_n     (cs_n),
        .miso     (miso)
    );

    always #5 clk = ~clk;

    // Cycle counter used to time events relative to the accept edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Target model: bit position advances on each SCLK fall, restarts on deselect.
    always @(negedge sclk or posedge cs_n) begin
        if (cs_n) tgt_cnt <= 3'd0;
        else      tgt_cnt <= tgt_cnt + 3'd1;
    end
    assign miso = loopback ? mosi : tgt_word[3'd7 - tgt_cnt];

    // Capture of MOSI at each SCLK rise, as the target would see it.
    always @(posedge sclk) mosi_cap <= {mosi_cap[6:0], mosi};

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rx_valid) begin
            rx_seen = rx_seen + 1;
            vec_cnt = vec_cnt + 1;
            if (exp_q.size() == 0) begin
                err_cnt = err_cnt + 1;
                $display("FAIL rx_unexpected: got rx_data=%02h with no word expected", rx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rx_data !== e) begin
                    err_cnt = err_cnt + 1;
                    $display("FAIL rx_data: got %02h expected %02h", rx_data, e);
                end
            end
        end
    end

    // Frame observer for the multi-word test.
    always @(negedge clk) begin
        if (watch) begin
            if (cs_n) cs_high_cnt = cs_high_cnt + 1;
            if (busy && tx_ready) wait_cyc_cnt = wait_cyc_cnt + 1;
            if (rx_valid) rxv_cnt = rxv_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt = vec_cnt + 1;
        if (act !== exp) begin
            err_cnt = err_cnt + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic l, input logic hold, output int t0);
        int n;
        n = 0;
        @(negedge clk);
        tx_data  = d;
        tx_last  = l;
        tx_valid = 1'b1;
        while (!tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        t0 = cyc;
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_rx(input int n);
        int k;
        k = 0;
        while (rx_seen < n && k < 2000) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("rx_count", rx_seen, n);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (!(tx_ready && !busy) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("return_idle", {31'd0, tx_ready & ~busy}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t0, t1, t2, t3, base, bad;
        logic m;
        rst_n    = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        loopback = 1'b0;
        tgt_word = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_cs_n", cs_n, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_tx_ready", tx_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_tx_ready", tx_ready, 1);

        // Test 1: single word A5, target returns 3C, full timing
        tgt_word = 8'h3C;
        exp_q.push_back(8'h3C);
        send(8'hA5, 1'b1, 1'b0, t0);
        chk("t1_cs_low", cs_n, 0);
        wait_cyc(t0 + 3);  chk("t1_sclk_pre_rise", sclk, 0);
        wait_cyc(t0 + 4);  chk("t1_first_rise", sclk, 1);
        wait_cyc(t0 + 67); chk("t1_rxv_early", rx_valid, 0);
        wait_cyc(t0 + 68); chk("t1_rxv_at_68", rx_valid, 1);
        wait_cyc(t0 + 71); chk("t1_cs_still_low", cs_n, 0);
        wait_cyc(t0 + 72); chk("t1_cs_high_72", cs_n, 1);
        wait_cyc(t0 + 75); chk("t1_not_ready_75", tx_ready, 0);
        wait_cyc(t0 + 76); chk("t1_ready_76", tx_ready, 1);
        chk("t1_mosi_bits", mosi_cap, 8'hA5);
        chk("t1_rx_data_hold", rx_data, 8'h3C);

        // Test 2: three-word frame with tx_valid held high
        tgt_word = 8'h5A;
        base = rx_seen;
        repeat (3) exp_q.push_back(8'h5A);
        cs_high_cnt = 0; wait_cyc_cnt = 0; rxv_cnt = 0;
        send(8'h01, 1'b0, 1'b1, t1);
        watch = 1'b1;
        send(8'h02, 1'b0, 1'b1, t2);
        send(8'h03, 1'b1, 1'b0, t3);
        wait_rx(base + 3);
        watch = 1'b0;
        chk("t2_cs_stays_low", cs_high_cnt, 0);
        chk("t2_rxv_pulses", rxv_cnt, 3);
        chk("t2_wait_cycles", wait_cyc_cnt, 2);
        chk("t2_spacing_12", t2 - t1, 69);
        chk("t2_spacing_23", t3 - t2, 69);
        wait_idle();

        // Test 3: loopback stream 00, FF, 81
        loopback = 1'b1;
        base = rx_seen;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h81);
        send(8'h00, 1'b0, 1'b1, t0);
        send(8'hFF, 1'b0, 1'b1, t0);
        send(8'h81, 1'b1, 1'b0, t0);
        wait_rx(base + 3);
        wait_idle();

        // Test 4: reset after the 3rd sclk rise of F0, then a clean 0F
        loopback = 1'b0;
        base = rx_seen;
        send(8'hF0, 1'b1, 1'b0, t0);
        wait_cyc(t0 + 20); chk("t4_third_rise", sclk, 1);
        chk("t4_mosi_before", mosi, 1);
        wait_cyc(t0 + 21);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t4_rst_cs_n", cs_n, 1);
        chk("t4_rst_sclk", sclk, 0);
        chk("t4_rst_mosi", mosi, 0);
        chk("t4_rst_rxv", rx_valid, 0);
        chk("t4_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("t4_no_partial_rx", rx_seen, base);
        loopback = 1'b1;
        exp_q.push_back(8'h0F);
        send(8'h0F, 1'b1, 1'b0, t0);
        wait_rx(base + 1);
        chk("t4_mosi_bits", mosi_cap, 8'h0F);
        wait_idle();

        // Test 5: non-last word, 50 idle cycles in WAIT, then resume
        base = rx_seen;
        exp_q.push_back(8'h12);
        send(8'h12, 1'b0, 1'b0, t0);
        wait_rx(base + 1);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cs_n !== 1'b0 || sclk !== 1'b0 || busy !== 1'b1 || tx_ready !== 1'b1) bad++;
        end
        chk("t5_wait_static", bad, 0);
        exp_q.push_back(8'h34);
        send(8'h34, 1'b1, 1'b0, t0);
        chk("t5_resume_cs_low", cs_n, 0);
        wait_rx(base + 2);
        wait_idle();

        // Test 6: tx_valid pulse during XFER is ignored
        base = rx_seen;
        exp_q.push_back(8'h56);
        send(8'h56, 1'b1, 1'b0, t0);
        wait_cyc(t0 + 10);
        tx_data  = 8'hFF;
        tx_last  = 1'b0;
        tx_valid = 1'b1;
        chk("t6_not_ready", tx_ready, 0);
        m = mosi;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("t6_mosi_unchanged", mosi, m);
        wait_rx(base + 1);
        chk("t6_mosi_bits", mosi_cap, 8'h56);
        wait_idle();

        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
